uart_tx_byte: RTL and testbench

- Serial transmitter for Tiny Tapeout-style project tops: takes a byte presented on dedicated inputs and shifts it out as an 8N1 UART frame on a single output pin.
- It is the output-direction counterpart to the input-sampling logic in our project wrappers. A receiving host or a sibling RX block reconstructs the byte.
- Instantiated inside the project top: tx_data driven from ui_in, txd driven to a uo_out bit, tx_busy and tx_done routed to spare uo_out bits.

---
 rtl/uart_tx_byte.sv | 153 +++++++++++++++
 tb/tb_uart_tx_byte.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter: accepts a byte on tx_start and shifts it out LSB first on txd.
// A start request on the stop bit's final edge chains the next frame with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  state_t           state_s;
  logic [7:0]       shift_r;
  logic [7:0]       shift_s;
  logic [2:0]       bit_idx_r;
  logic [2:0]       bit_idx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             txd_r;
  logic             txd_s;
  logic             busy_r;
  logic             busy_s;
  logic             done_r;
  logic             done_s;
  logic             bit_end_s;
  logic             accept_s;

  assign bit_end_s = (cnt_r == LAST_CNT);
  // A new frame may start from IDLE or on the last edge of the stop bit.
  assign accept_s  = tx_start & ((state_r == IDLE) | ((state_r == STOP) & bit_end_s));

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      shift_r   <= 8'h00;
      bit_idx_r <= 3'd0;
      cnt_r     <= '0;
      txd_r     <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bit_idx_r <= bit_idx_s;
      cnt_r     <= cnt_s;
      txd_r     <= txd_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bit_idx_s = bit_idx_r;
    if (bit_end_s) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + CNT_ONE;
    end
    case (state_r)
      IDLE: begin
        cnt_s = '0;
        if (accept_s) begin
          state_s = START;
          shift_s = tx_data;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s   = DATA;
          bit_idx_s = 3'd0;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_s   = {1'b0, shift_r[7:1]};
          bit_idx_s = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
            state_s = STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (accept_s) begin
          state_s = START;
          shift_s = tx_data;
        end else if (bit_end_s) begin
          state_s = IDLE;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s   = IDLE;
        shift_s   = 8'h00;
        bit_idx_s = 3'd0;
        cnt_s     = '0;
      end
    endcase
  end

  // Output values for the state being entered, so the flops line up with it.
  always_comb begin
    case (state_s)
      START:   txd_s = 1'b0;
      DATA:    txd_s = shift_s[0];
      STOP:    txd_s = 1'b1;
      IDLE:    txd_s = 1'b1;
      default: txd_s = 1'b1;
    endcase
    if (state_s == IDLE) begin
      busy_s = 1'b0;
    end else begin
      busy_s = 1'b1;
    end
    if ((state_r == STOP) && bit_end_s) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
  end

  assign txd     = txd_r;
  assign tx_busy = busy_r;
  assign tx_done = done_r;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Random and directed stimulus on three transmitters (4, 2 and 13 clocks per bit); a
// line-decoding receiver model checks every frame against a queue of expected bytes.
module tb_uart_tx_byte;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       txd_v  [3];
  logic       busy_v [3];
  logic       done_v [3];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit end_req = 1'b0;
  bit end_ack = 1'b0;

  // Expected frames per lane: {data, acceptance cycle}.
  logic [39:0] q0[$];
  logic [39:0] q1[$];
  logic [39:0] q2[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    uart_tx_byte #(
      .CLKS_PER_BIT((g == 0) ? 4 : ((g == 1) ? 2 : 13)),
      .CNT_W       (12)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tx_data (tx_data),
      .tx_start(tx_start),
      .txd     (txd_v[g]),
      .tx_busy (busy_v[g]),
      .tx_done (done_v[g])
    );
  end

  function automatic int cpb(input int l);
    case (l)
      0:       return 4;
      1:       return 2;
      default: return 13;
    endcase
  endfunction

  function automatic void q_push(input int l, input logic [39:0] e);
    case (l)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int q_size(input int l);
    case (l)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [39:0] q_pop(input int l);
    case (l)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void q_clear(input int l);
    case (l)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  task automatic check(input bit ok, input string name, input int l,
                       input longint act, input longint exp_v);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s lane%0d(cpb=%0d) cyc=%0d: got %0h expected %0h",
               name, l, cpb(l), cyc, act, exp_v);
    end
  endtask

  // Receiver / scoreboard state per lane.
  bit          in_frame [3];
  int          s_cyc    [3];
  int          done_due [3];
  int          free_at  [3];
  int          werr     [3];
  logic [9:0]  slot     [3];
  logic [7:0]  exp_byte [3];
  logic [39:0] ent;
  int          c;
  int          d;
  int          k;
  bit          exp_done;

  initial begin
    for (int l = 0; l < 3; l++) begin
      in_frame[l] = 1'b0;
      done_due[l] = -1;
      free_at[l]  = 0;
      werr[l]     = 0;
      slot[l]     = 10'h0;
      exp_byte[l] = 8'h00;
    end
  end

  // Monitor then reference model, both on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      c = cpb(l);
      if (!rst_n) begin
        check(txd_v[l] === 1'b1, "reset_txd", l, longint'(txd_v[l]), 1);
        check(busy_v[l] === 1'b0, "reset_busy", l, longint'(busy_v[l]), 0);
        check(done_v[l] === 1'b0, "reset_done", l, longint'(done_v[l]), 0);
        in_frame[l] = 1'b0;
        done_due[l] = -1;
        free_at[l]  = 0;
        q_clear(l);
      end else begin
        exp_done = (cyc == done_due[l]);
        if (exp_done || (done_v[l] !== 1'b0)) begin
          check(done_v[l] === exp_done, "tx_done", l, longint'(done_v[l]), longint'(exp_done));
        end
        if (!in_frame[l] && (txd_v[l] === 1'b0)) begin
          in_frame[l] = 1'b1;
          s_cyc[l]    = cyc;
          werr[l]     = 0;
          if (q_size(l) == 0) begin
            check(1'b0, "spurious_frame", l, cyc, -1);
            exp_byte[l] = 8'h00;
          end else begin
            ent = q_pop(l);
            exp_byte[l] = ent[39:32];
            check(int'(ent[31:0]) == cyc, "start_cycle", l, cyc, longint'(ent[31:0]));
          end
        end
        check(busy_v[l] === in_frame[l], "tx_busy", l, longint'(busy_v[l]), longint'(in_frame[l]));
        if (in_frame[l]) begin
          d = cyc - s_cyc[l];
          k = d / c;
          if ((d % c) == 0) begin
            slot[l][k] = txd_v[l];
          end else if (txd_v[l] !== slot[l][k]) begin
            werr[l]++;
          end
          if (d == 10 * c - 1) begin
            check(slot[l] == {1'b1, exp_byte[l], 1'b0}, "frame", l,
                  longint'(slot[l]), longint'({1'b1, exp_byte[l], 1'b0}));
            check(werr[l] == 0, "bit_width", l, werr[l], 0);
            in_frame[l] = 1'b0;
            done_due[l] = cyc + 1;
          end
        end
        // Reference: a start is taken whenever the previous frame has used its 10 bit times.
        if ((tx_start === 1'b1) && (cyc + 1 >= free_at[l])) begin
          q_push(l, {tx_data, 32'(cyc + 1)});
          free_at[l] = cyc + 1 + 10 * c;
        end
      end
      if (end_req && !end_ack) begin
        check(q_size(l) == 0, "pending_frames", l, q_size(l), 0);
        check(!in_frame[l], "frame_open", l, longint'(in_frame[l]), 0);
      end
    end
    if (end_req) end_ack = 1'b1;
  end

  task automatic drive(input logic s, input logic [7:0] dt, input int n);
    for (int i = 0; i < n; i++) begin
      tx_start = s;
      tx_data  = dt;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    #2;
    rst_n    = 1'b0;
    tx_start = 1'b1;
    tx_data  = 8'hC3;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 8'hC3, 1);
    drive(1'b0, 8'h00, 140);
    // Single byte.
    drive(1'b1, 8'hA5, 1);
    drive(1'b0, 8'h00, 140);
    // Start request and data change during a frame must be ignored.
    drive(1'b1, 8'h3C, 1);
    drive(1'b0, 8'h3C, 11);
    drive(1'b1, 8'hFF, 1);
    drive(1'b0, 8'hFF, 140);
    // Held start: back-to-back frames.
    drive(1'b1, 8'h00, 40);
    drive(1'b1, 8'hFF, 1);
    drive(1'b0, 8'hFF, 140);
    // Reset mid-frame, then a clean frame.
    drive(1'b1, 8'h55, 1);
    drive(1'b0, 8'h55, 16);
    rst_n = 1'b0;
    drive(1'b0, 8'h55, 3);
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 2);
    drive(1'b1, 8'h81, 1);
    drive(1'b0, 8'h81, 140);
    drive(1'b1, 8'h6B, 1);
    drive(1'b0, 8'h6B, 140);
    // Random start patterns and data.
    for (int i = 0; i < 25; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 30));
    end
    drive(1'b0, 8'h00, 140);
    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) @(posedge clk);
    if (!end_ack) begin
      $display("FAIL end_check: monitor did not acknowledge");
      $fatal(1, "end check timeout");
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
